// File: rtl/seg7_output_display.sv
// Output-register consumer: captures an 8-bit value, converts it to BCD with a sequential
// double-dabble engine and scans it onto a 4-digit 7-segment display. Optional macro: SEG7_LEADING_BLANK_EN.
module seg7_output_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  data,
    input  logic        signed_mode,
    output logic [6:0]  seg,
    output logic [3:0]  digit_en,
    output logic        busy,
    output logic [11:0] value_bcd,
    output logic        neg
);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t state, state_nxt;

    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [2:0]  iter;
    logic        neg_work;
    logic        pend_vld;
    logic [7:0]  pend_data;
    logic        pend_signed;

    logic        start;
    logic [7:0]  src_data;
    logic        src_signed;
    logic        src_neg;
    logic [7:0]  src_mag;
    logic [11:0] bcd_adj;

    logic [PW-1:0] presc;
    logic [1:0]    scan_idx;
    logic          blank_h;
    logic          blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0: dec7 = 7'h3F;
            4'd1: dec7 = 7'h06;
            4'd2: dec7 = 7'h5B;
            4'd3: dec7 = 7'h4F;
            4'd4: dec7 = 7'h66;
            4'd5: dec7 = 7'h6D;
            4'd6: dec7 = 7'h7D;
            4'd7: dec7 = 7'h07;
            4'd8: dec7 = 7'h7F;
            4'd9: dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    // A fresh load in IDLE takes precedence over (and overwrites) the pending slot.
    assign start      = (state == IDLE) && (load || pend_vld);
    assign src_data   = load ? data : pend_data;
    assign src_signed = load ? signed_mode : pend_signed;
    assign src_neg    = src_signed & src_data[7];
    assign src_mag    = src_neg ? (~src_data + 8'd1) : src_data;
    assign bcd_adj    = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load || pend_vld) state_nxt = CONV;
            CONV:    if (iter == 3'd7) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mag         <= '0;
            bcd         <= '0;
            iter        <= '0;
            neg_work    <= 1'b0;
            value_bcd   <= '0;
            neg         <= 1'b0;
            pend_vld    <= 1'b0;
            pend_data   <= '0;
            pend_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mag      <= src_mag;
                    neg_work <= src_neg;
                    bcd      <= '0;
                    iter     <= '0;
                end
                CONV: begin
                    bcd  <= {bcd_adj[10:0], mag[7]};
                    mag  <= {mag[6:0], 1'b0};
                    iter <= iter + 3'd1;
                end
                COMMIT: begin
                    value_bcd <= bcd;
                    neg       <= neg_work;
                end
                default: ;
            endcase
            if (load && state != IDLE) begin
                pend_vld    <= 1'b1;
                pend_data   <= data;
                pend_signed <= signed_mode;
            end else if (start) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Scan runs free of the conversion FSM.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc    <= '0;
            scan_idx <= '0;
            digit_en <= 4'b0001;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= scan_idx + 2'd1;
            digit_en <= {digit_en[2:0], digit_en[3]};
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef SEG7_LEADING_BLANK_EN
    assign blank_h = (value_bcd[11:8] == 4'd0);
    assign blank_t = blank_h && (value_bcd[7:4] == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        seg = 7'h00;
        case (scan_idx)
            2'd0: seg = dec7(value_bcd[3:0]);
            2'd1: seg = blank_t ? 7'h00 : dec7(value_bcd[7:4]);
            2'd2: seg = blank_h ? 7'h00 : dec7(value_bcd[11:8]);
            2'd3: seg = neg ? 7'h40 : 7'h00;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: tb/tb_seg7_output_display.sv
// Scoreboard bench for seg7_output_display: stimulus pushes expected commits, a monitor pops them on busy falling.
module tb_seg7_output_display;
    localparam int SCAN_DIV = 4;
`ifdef SEG7_LEADING_BLANK_EN
    localparam logic [6:0] ZB = 7'h00;
`else
    localparam logic [6:0] ZB = 7'h3F;
`endif

    logic        clk = 1'b0, clr = 1'b0, load = 1'b0, signed_mode = 1'b0;
    logic [7:0]  data = 8'd0;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        busy, neg;
    logic [11:0] value_bcd;

    int n_vec = 0, n_bad = 0, cyc = 0;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        int          at;
    } exp_t;
    exp_t sb[$];

    seg7_output_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .clr(clr), .load(load), .data(data), .signed_mode(signed_mode),
        .seg(seg), .digit_en(digit_en), .busy(busy), .value_bcd(value_bcd), .neg(neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Commit monitor: a busy 1->0 transition outside reset is one commit.
    logic busy_q = 1'b0, clr_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (clr && clr_q && busy_q && !busy) begin
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_commit: got %03h expected none", value_bcd);
            end else begin
                e = sb.pop_front();
                chk("commit_bcd", 32'(value_bcd), 32'(e.bcd));
                chk("commit_neg", 32'(neg), 32'(e.neg));
                chk("commit_edge", cyc, e.at);
            end
        end
        busy_q = busy;
        clr_q  = clr;
    end

    task automatic do_load(input logic [7:0] d, input logic sm, output int k);
        @(negedge clk);
        load = 1'b1; data = d; signed_mode = sm;
        @(posedge clk); #1;
        k = cyc;
        load = 1'b0;
    endtask

    task automatic expect_commit(input logic [11:0] b, input logic n, input int at);
        exp_t e;
        e.bcd = b; e.neg = n; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle_timeout", 32'(t >= 100), 32'd0);
    endtask

    task automatic check_digits(input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] want;
            int t;
            want = 4'b0001 << i;
            t = 0;
            @(negedge clk);
            while (digit_en !== want && t < 4 * SCAN_DIV + 2) begin
                @(negedge clk);
                t++;
            end
            chk("digit_en_seen", 32'(digit_en), 32'(want));
            chk($sformatf("seg_digit%0d", i), 32'(seg), 32'(ex[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        logic [3:0] de;
        repeat (2) @(negedge clk);
        chk("rst_value_bcd", 32'(value_bcd), 32'h000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_digit_en", 32'(digit_en), 32'h1);
        chk("rst_seg", 32'(seg), 32'h3F);
        clr = 1'b1;

        // scan walk with no load
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                repeat (SCAN_DIV) @(posedge clk);
                #1;
            end
            de = 4'b0001 << (i % 4);
            chk("scan_digit_en", 32'(digit_en), 32'(de));
            case (i % 4)
                0:       chk("scan_seg", 32'(seg), 32'h3F);
                3:       chk("scan_seg", 32'(seg), 32'h00);
                default: chk("scan_seg", 32'(seg), 32'(ZB));
            endcase
        end
        chk("scan_value_bcd", 32'(value_bcd), 32'h000);
        chk("scan_busy", 32'(busy), 32'd0);

        // unsigned 123 with busy window
        do_load(8'd123, 1'b0, k);
        expect_commit(12'h123, 1'b0, k + 9);
        chk("busy_k1", 32'(busy), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("busy_k8", 32'(busy), 32'd1);
        wait_idle();
        check_digits(7'h00, 7'h06, 7'h5B, 7'h4F);

        // signed values
        do_load(8'hFF, 1'b1, k);
        expect_commit(12'h001, 1'b1, k + 9);
        wait_idle();
        check_digits(7'h40, ZB, ZB, 7'h06);
        do_load(8'h80, 1'b1, k);
        expect_commit(12'h128, 1'b1, k + 9);
        wait_idle();
        check_digits(7'h40, 7'h06, 7'h5B, 7'h7F);
        do_load(8'h7F, 1'b1, k);
        expect_commit(12'h127, 1'b0, k + 9);
        wait_idle();
        check_digits(7'h00, 7'h06, 7'h5B, 7'h07);

        // pending slot: 9 is overwritten by 42
        do_load(8'd255, 1'b0, k);
        expect_commit(12'h255, 1'b0, k + 9);
        repeat (2) @(posedge clk);
        do_load(8'd9, 1'b0, k2);
        chk("pend_load1_edge", k2, k + 3);
        @(posedge clk);
        do_load(8'd42, 1'b0, k2);
        chk("pend_load2_edge", k2, k + 5);
        expect_commit(12'h042, 1'b0, k + 19);
        wait_idle();
        check_digits(7'h00, ZB, 7'h66, 7'h5B);

        // reset mid-conversion
        do_load(8'd200, 1'b0, k);
        expect_commit(12'h200, 1'b0, k + 9);
        wait_idle();
        do_load(8'd77, 1'b0, k);
        repeat (4) @(posedge clk);
        #1 clr = 1'b0;
        #1;
        chk("clr_value_bcd", 32'(value_bcd), 32'h000);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_digit_en", 32'(digit_en), 32'h1);
        chk("clr_neg", 32'(neg), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_clr_value_bcd", 32'(value_bcd), 32'h000);
        chk("post_clr_busy", 32'(busy), 32'd0);

        // leading-zero case
        do_load(8'd7, 1'b0, k);
        expect_commit(12'h007, 1'b0, k + 9);
        wait_idle();
        check_digits(7'h00, ZB, ZB, 7'h07);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
